// File: rtl/bcd_counter_chain_if.sv
// Bus bundle for the multi-digit BCD counter: control and load inputs
// flow from the master (game logic) to the slave (counter). The count
// and status flags flow back.
interface bcd_counter_chain_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int W = 4 * NUM_DIGITS;

  logic         loadN;
  logic         clear;
  logic         ena;
  logic         ena_cnt;
  logic         countDownMode;
  logic         saturate;
  logic [W-1:0] datain;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap_pulse;
  logic         at_limit;

  modport master (
    output loadN, clear, ena, ena_cnt, countDownMode, saturate, datain,
    input  count, tc, wrap_pulse, at_limit
  );

  modport slave (
    input  loadN, clear, ena, ena_cnt, countDownMode, saturate, datain,
    output count, tc, wrap_pulse, at_limit
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with parallel load, synchronous clear,
// and wrap or saturate behaviour at the limit. The whole carry/borrow chain
// is resolved combinationally, so every digit updates on the same edge.
// Nibble 0 is the least significant digit.
module bcd_counter_chain #(
  parameter int                      NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                resetN,
  bcd_counter_chain_if.slave  bus
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         wrapPulse_q, wrapPulse_d;
  logic         atLimit_q, atLimit_d;
  logic [W-1:0] stepped;
  logic         allNine;
  logic         allZero;
  logic         tc;
  logic         stepReq;

  // Next value for one step in the current direction. A single running
  // carry/borrow walks from digit 0 upwards. An illegal digit counts as
  // "full" going up (becomes 0 and carries). Going down, it becomes 9
  // and stops the borrow.
  always_comb begin
    logic chain;
    stepped = count_q;
    chain   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (chain) begin
        if (bus.countDownMode) begin
          if (count_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else if (count_q[4*i +: 4] > 4'd9) begin
            stepped[4*i +: 4] = 4'd9;
            chain = 1'b0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
  end

  // Terminal-count detection. An illegal nibble is neither 9 nor 0, so it
  // can never raise tc.
  always_comb begin
    allNine = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) allNine = 1'b0;
    end
    allZero = (count_q == '0);
    tc      = bus.countDownMode ? allZero : allNine;
  end

  assign stepReq = bus.ena && bus.ena_cnt;

  // Priority of load, then clear, then step, then hold. Load and clear
  // bypass ena and drop both flags. A step at the limit either wraps
  // (pulse) or holds (at_limit). A plain hold keeps at_limit unchanged.
  always_comb begin
    count_d     = count_q;
    wrapPulse_d = 1'b0;
    atLimit_d   = atLimit_q;
    if (!bus.loadN) begin
      count_d   = bus.datain;
      atLimit_d = 1'b0;
    end else if (bus.clear) begin
      count_d   = '0;
      atLimit_d = 1'b0;
    end else if (stepReq) begin
      if (tc && bus.saturate) begin
        atLimit_d = 1'b1;
      end else begin
        count_d     = stepped;
        wrapPulse_d = tc;
        atLimit_d   = 1'b0;
      end
    end
  end

  // State registers. An asynchronous reset abandons any step in progress
  // and returns to the configured start value.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q     <= INIT_VALUE;
      wrapPulse_q <= 1'b0;
      atLimit_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      wrapPulse_q <= wrapPulse_d;
      atLimit_q   <= atLimit_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc;
  assign bus.wrap_pulse = wrapPulse_q;
  assign bus.at_limit   = atLimit_q;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for the 3-digit BCD counter chain. A second instance with
// a non-zero start value exercises asynchronous reset mid-count.
module tb_bcd_counter_chain;
  logic clk;
  logic resetN;
  logic resetN2;
  int   assertCount;
  int   failCount;

  bcd_counter_chain_if #(.NUM_DIGITS(3)) bus1 ();
  bcd_counter_chain_if #(.NUM_DIGITS(3)) bus2 ();

  bcd_counter_chain #(.NUM_DIGITS(3), .INIT_VALUE(12'h000)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus1)
  );

  bcd_counter_chain #(.NUM_DIGITS(3), .INIT_VALUE(12'h050)) dutInit (
    .clk    (clk),
    .resetN (resetN2),
    .bus    (bus2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [11:0] v);
    bus1.datain = v;
    bus1.loadN  = 1'b0;
    tick();
    bus1.loadN  = 1'b1;
  endtask

  task automatic stepOnce();
    bus1.ena_cnt = 1'b1;
    tick();
    bus1.ena_cnt = 1'b0;
  endtask

  task automatic test_reset();
    resetN  = 1'b1;
    resetN2 = 1'b1;
    #2;
    resetN  = 1'b0;
    resetN2 = 1'b0;
    #2;
    assertCount++;
    if (bus1.count !== 12'h000) begin
      failCount++;
      $display("[TB] FAIL reset_count: got %h want %h", bus1.count, 12'h000);
    end
    assertCount++;
    if (bus1.wrap_pulse !== 1'b0 || bus1.at_limit !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got wrap=%b lim=%b want 0 0", bus1.wrap_pulse, bus1.at_limit);
    end
    assertCount++;
    if (bus2.count !== 12'h050) begin
      failCount++;
      $display("[TB] FAIL reset_init: got %h want %h", bus2.count, 12'h050);
    end
    #3;
    resetN  = 1'b1;
    resetN2 = 1'b1;
    tick();
  endtask

  task automatic test_up_count();
    int wrapSeen;
    wrapSeen = 0;
    bus1.ena_cnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus1.wrap_pulse !== 1'b0) wrapSeen++;
    end
    bus1.ena_cnt = 1'b0;
    assertCount++;
    if (bus1.count !== 12'h012) begin
      failCount++;
      $display("[TB] FAIL up_count: got %h want %h", bus1.count, 12'h012);
    end
    assertCount++;
    if (bus1.tc !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL up_count_tc: got %b want 0", bus1.tc);
    end
    assertCount++;
    if (wrapSeen !== 0) begin
      failCount++;
      $display("[TB] FAIL up_count_wrap: got %0d pulses want 0", wrapSeen);
    end
  endtask

  task automatic test_double_carry();
    loadValue(12'h199);
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h200) begin
      failCount++;
      $display("[TB] FAIL double_carry: got %h want %h", bus1.count, 12'h200);
    end
    bus1.ena     = 1'b0;
    bus1.ena_cnt = 1'b1;
    tick();
    bus1.ena_cnt = 1'b0;
    bus1.ena     = 1'b1;
    assertCount++;
    if (bus1.count !== 12'h200) begin
      failCount++;
      $display("[TB] FAIL ena_hold: got %h want %h", bus1.count, 12'h200);
    end
  endtask

  task automatic test_wrap_up();
    loadValue(12'h999);
    assertCount++;
    if (bus1.tc !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tc_up_999: got %b want 1", bus1.tc);
    end
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h000 || bus1.wrap_pulse !== 1'b1 || bus1.at_limit !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wrap_up: got %h wrap=%b lim=%b want 000 1 0", bus1.count, bus1.wrap_pulse, bus1.at_limit);
    end
    tick();
    assertCount++;
    if (bus1.wrap_pulse !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL wrap_up_pulse_len: got %b want 0", bus1.wrap_pulse);
    end
  endtask

  task automatic test_saturate_up();
    bus1.saturate = 1'b1;
    loadValue(12'h999);
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h999 || bus1.at_limit !== 1'b1 || bus1.wrap_pulse !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sat_up: got %h lim=%b wrap=%b want 999 1 0", bus1.count, bus1.at_limit, bus1.wrap_pulse);
    end
    tick();
    assertCount++;
    if (bus1.at_limit !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sat_up_keep: got %b want 1", bus1.at_limit);
    end
    bus1.saturate = 1'b0;
  endtask

  task automatic test_down();
    bus1.countDownMode = 1'b1;
    loadValue(12'h100);
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h099) begin
      failCount++;
      $display("[TB] FAIL down_borrow: got %h want %h", bus1.count, 12'h099);
    end
    loadValue(12'h000);
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h999 || bus1.wrap_pulse !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL wrap_down: got %h wrap=%b want 999 1", bus1.count, bus1.wrap_pulse);
    end
    bus1.saturate = 1'b1;
    loadValue(12'h000);
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h000 || bus1.tc !== 1'b1 || bus1.at_limit !== 1'b1 || bus1.wrap_pulse !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sat_down: got %h tc=%b lim=%b wrap=%b want 000 1 1 0", bus1.count, bus1.tc, bus1.at_limit, bus1.wrap_pulse);
    end
    bus1.saturate = 1'b0;
  endtask

  task automatic test_priority();
    bus1.datain  = 12'h345;
    bus1.loadN   = 1'b0;
    bus1.clear   = 1'b1;
    bus1.ena_cnt = 1'b1;
    tick();
    bus1.loadN = 1'b1;
    assertCount++;
    if (bus1.count !== 12'h345 || bus1.at_limit !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL load_wins: got %h lim=%b want 345 0", bus1.count, bus1.at_limit);
    end
    tick();
    bus1.clear   = 1'b0;
    bus1.ena_cnt = 1'b0;
    assertCount++;
    if (bus1.count !== 12'h000) begin
      failCount++;
      $display("[TB] FAIL clear_wins: got %h want %h", bus1.count, 12'h000);
    end
  endtask

  task automatic test_direction_tc();
    bus1.countDownMode = 1'b0;
    #1;
    assertCount++;
    if (bus1.tc !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL tc_up_zero: got %b want 0", bus1.tc);
    end
    bus1.countDownMode = 1'b1;
    #1;
    assertCount++;
    if (bus1.tc !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tc_down_zero: got %b want 1", bus1.tc);
    end
    bus1.countDownMode = 1'b0;
  endtask

  task automatic test_init_reset();
    bus2.ena_cnt = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus2.ena_cnt = 1'b0;
    assertCount++;
    if (bus2.count !== 12'h057) begin
      failCount++;
      $display("[TB] FAIL init_count: got %h want %h", bus2.count, 12'h057);
    end
    #3;
    resetN2 = 1'b0;
    #1;
    assertCount++;
    if (bus2.count !== 12'h050 || bus2.wrap_pulse !== 1'b0 || bus2.at_limit !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got %h wrap=%b lim=%b want 050 0 0", bus2.count, bus2.wrap_pulse, bus2.at_limit);
    end
    #2;
    resetN2 = 1'b1;
    bus2.ena_cnt = 1'b1;
    tick();
    bus2.ena_cnt = 1'b0;
    assertCount++;
    if (bus2.count !== 12'h051) begin
      failCount++;
      $display("[TB] FAIL first_step_after_reset: got %h want %h", bus2.count, 12'h051);
    end
  endtask

  task automatic test_illegal();
    loadValue(12'h00C);
    tick();
    assertCount++;
    if (bus1.count !== 12'h00C || bus1.tc !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL illegal_hold: got %h tc=%b want 00c 0", bus1.count, bus1.tc);
    end
    bus1.countDownMode = 1'b1;
    #1;
    assertCount++;
    if (bus1.tc !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL illegal_tc_down: got %b want 0", bus1.tc);
    end
    bus1.countDownMode = 1'b0;
    stepOnce();
    assertCount++;
    if (bus1.count !== 12'h010) begin
      failCount++;
      $display("[TB] FAIL illegal_up: got %h want %h", bus1.count, 12'h010);
    end
    bus1.countDownMode = 1'b1;
    loadValue(12'h00C);
    stepOnce();
    bus1.countDownMode = 1'b0;
    assertCount++;
    if (bus1.count !== 12'h009) begin
      failCount++;
      $display("[TB] FAIL illegal_down: got %h want %h", bus1.count, 12'h009);
    end
  endtask

  // Scenario sequence.
  initial begin
    assertCount = 0;
    failCount   = 0;
    resetN      = 1'b1;
    resetN2     = 1'b1;
    bus1.loadN = 1'b1; bus1.clear = 1'b0; bus1.ena = 1'b1; bus1.ena_cnt = 1'b0;
    bus1.countDownMode = 1'b0; bus1.saturate = 1'b0; bus1.datain = 12'h000;
    bus2.loadN = 1'b1; bus2.clear = 1'b0; bus2.ena = 1'b1; bus2.ena_cnt = 1'b0;
    bus2.countDownMode = 1'b0; bus2.saturate = 1'b0; bus2.datain = 12'h000;

    test_reset();
    test_up_count();
    test_double_carry();
    test_wrap_up();
    test_saturate_up();
    test_down();
    test_priority();
    test_direction_tc();
    test_init_reset();
    test_illegal();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
